// File: rtl/micro_udp_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : micro_udp_engine_pkg
//  Description : Shared types and constants for the micro UDP engine.
//                - arp_packet_t : 224-bit ARP payload, MSB first (shared RX/TX)
//                - arp_oper_e   : ARP operation codes
//                - ARP_* / ETH_* constants and the arp_build() helper
//  Revision    : 1.0 - initial ARP TX support
// ============================================================================
package micro_udp_engine_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH      = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4     = 8'd4;
  localparam int          ARP_PAYLOAD_BITS  = 224;
  localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Reply queue entry: {tha[47:0], tpa[31:0]}
  localparam int          ARP_REPLY_ENTRY_BITS = 80;

  typedef enum logic [15:0] {
    ARP_OPER_REQUEST = 16'd1,
    ARP_OPER_REPLY   = 16'd2
  } arp_oper_e;

  typedef struct packed {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_packet_t;

  function automatic arp_packet_t arp_build(
    input arp_oper_e   oper,
    input logic [47:0] sha,
    input logic [31:0] spa,
    input logic [47:0] tha,
    input logic [31:0] tpa
  );
    arp_packet_t pkt;
    pkt.htype = ARP_HTYPE_ETH;
    pkt.ptype = ARP_PTYPE_IPV4;
    pkt.hlen  = ARP_HLEN_ETH;
    pkt.plen  = ARP_PLEN_IPV4;
    pkt.oper  = oper;
    pkt.sha   = sha;
    pkt.spa   = spa;
    pkt.tha   = tha;
    pkt.tpa   = tpa;
    return pkt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/micro_udp_engine_arp_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : micro_udp_engine_arp_tx_fifo
//  Description : Synchronous queue for pending ARP replies.
//                A push while full is accepted only when a pop happens in the
//                same cycle; otherwise it is ignored (caller counts drops).
//  Ports       : clk, reset          - clock, sync active-high reset
//                push, push_data     - write request and data
//                pop                 - read request (ignored when empty)
//                pop_data            - head entry (valid when !empty)
//                full, empty         - status flags
//  Revision    : 1.0 - initial version
// ============================================================================
module micro_udp_engine_arp_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 80
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/micro_udp_engine_arp_tx.sv
`default_nettype none
// ============================================================================
//  Module      : micro_udp_engine_arp_tx
//  Description : ARP transmit engine. Queues reply requests, holds one
//                resolution request, and emits single-beat ARP payloads on a
//                256-bit Avalon-ST source (payload in [255:32]).
//                Priority: queued reply > held request > gratuitous.
//                Optional macro ARP_TX_GRATUITOUS_EN adds a periodic
//                gratuitous ARP every GRAT_PERIOD clk cycles.
//  Ports       : clk, reset                      - clock, sync active-high reset
//                arp_reply, arp_reply_tha/_tpa   - reply enqueue pulse + target
//                arp_request_valid/_tpa/_ready   - resolution request handshake
//                arp_tx_*                        - Avalon-ST source + dst MAC
//                reply_drop_cnt                  - saturating drop counter
//  Revision    : 1.0 - initial version
// ============================================================================
module micro_udp_engine_arp_tx #(
  parameter logic [47:0] CONFIG_MAC_ADDR  = 48'h02_00_00_00_00_01,
  parameter logic [31:0] CONFIG_IP_ADDR   = 32'hC0A8_0001,
  parameter int          REPLY_FIFO_DEPTH = 4,
  parameter int          GRAT_PERIOD      = 125_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         arp_reply,
  input  logic [47:0]  arp_reply_tha,
  input  logic [31:0]  arp_reply_tpa,
  input  logic         arp_request_valid,
  input  logic [31:0]  arp_request_tpa,
  output logic         arp_request_ready,
  output logic [255:0] arp_tx_data,
  output logic [4:0]   arp_tx_empty,
  output logic         arp_tx_startofpacket,
  output logic         arp_tx_endofpacket,
  output logic         arp_tx_valid,
  input  logic         arp_tx_ready,
  output logic [47:0]  arp_tx_dst_mac,
  output logic [15:0]  reply_drop_cnt
);

  import micro_udp_engine_pkg::*;

  if ((REPLY_FIFO_DEPTH < 2) || (REPLY_FIFO_DEPTH > 16) ||
      ((REPLY_FIFO_DEPTH & (REPLY_FIFO_DEPTH - 1)) != 0) || (GRAT_PERIOD < 2)) begin : g_param_check
    $error("micro_udp_engine_arp_tx: illegal REPLY_FIFO_DEPTH or GRAT_PERIOD");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e      state;
  state_e      state_next;

  logic [ARP_REPLY_ENTRY_BITS-1:0] fifo_rd_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  logic        req_full;
  logic [31:0] req_tpa;
  logic        req_take;

  logic        load;
  arp_packet_t load_pkt;
  logic [47:0] load_dst;
  arp_packet_t tx_pkt;
  logic [47:0] tx_dst;

  // ---------------------------------------------------------------- reply queue
  micro_udp_engine_arp_tx_fifo #(
    .DEPTH (REPLY_FIFO_DEPTH),
    .WIDTH (ARP_REPLY_ENTRY_BITS)
  ) u_reply_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (arp_reply),
    .push_data ({arp_reply_tha, arp_reply_tpa}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A simultaneous pop frees the slot, so only full-without-pop drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      reply_drop_cnt <= '0;
    end else if (arp_reply && fifo_full && !fifo_pop && (reply_drop_cnt != 16'hFFFF)) begin
      reply_drop_cnt <= reply_drop_cnt + 16'd1;
    end
  end

  // --------------------------------------------------- request holding register
  assign arp_request_ready = !req_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_full <= 1'b0;
      req_tpa  <= '0;
    end else if (req_take) begin
      req_full <= 1'b0;
    end else if (arp_request_valid && !req_full) begin
      req_full <= 1'b1;
      req_tpa  <= arp_request_tpa;
    end
  end

  // ------------------------------------------------------- gratuitous ARP timer
`ifdef ARP_TX_GRATUITOUS_EN
  logic [31:0] grat_cnt;
  logic        grat_pending;
  logic        grat_take;
  logic        grat_wrap;

  assign grat_wrap = (grat_cnt == 32'(GRAT_PERIOD - 1));

  // A wrap while already pending just re-sets the flag; requests never stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      grat_cnt     <= '0;
      grat_pending <= 1'b0;
    end else begin
      grat_cnt <= grat_wrap ? 32'd0 : grat_cnt + 32'd1;
      if (grat_wrap)      grat_pending <= 1'b1;
      else if (grat_take) grat_pending <= 1'b0;
    end
  end
`endif

  // ------------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    req_take   = 1'b0;
    load       = 1'b0;
    load_pkt   = '0;
    load_dst   = '0;
`ifdef ARP_TX_GRATUITOUS_EN
    grat_take  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load       = 1'b1;
          load_pkt   = arp_build(ARP_OPER_REPLY, CONFIG_MAC_ADDR, CONFIG_IP_ADDR,
                                 fifo_rd_data[79:32], fifo_rd_data[31:0]);
          load_dst   = fifo_rd_data[79:32];
          state_next = ST_SEND;
        end else if (req_full) begin
          req_take   = 1'b1;
          load       = 1'b1;
          load_pkt   = arp_build(ARP_OPER_REQUEST, CONFIG_MAC_ADDR, CONFIG_IP_ADDR,
                                 48'h0, req_tpa);
          load_dst   = ETH_BROADCAST_MAC;
          state_next = ST_SEND;
        end
`ifdef ARP_TX_GRATUITOUS_EN
        else if (grat_pending) begin
          grat_take  = 1'b1;
          load       = 1'b1;
          load_pkt   = arp_build(ARP_OPER_REQUEST, CONFIG_MAC_ADDR, CONFIG_IP_ADDR,
                                 48'h0, CONFIG_IP_ADDR);
          load_dst   = ETH_BROADCAST_MAC;
          state_next = ST_SEND;
        end
`endif
      end
      ST_SEND: begin
        if (arp_tx_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- output register
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_pkt <= '0;
      tx_dst <= '0;
    end else if (load) begin
      tx_pkt <= load_pkt;
      tx_dst <= load_dst;
    end
  end

  assign arp_tx_valid         = (state == ST_SEND);
  assign arp_tx_startofpacket = arp_tx_valid;
  assign arp_tx_endofpacket   = arp_tx_valid;
  assign arp_tx_empty         = arp_tx_valid ? 5'd4 : 5'd0;
  assign arp_tx_data          = {tx_pkt, {(256 - ARP_PAYLOAD_BITS){1'b0}}};
  assign arp_tx_dst_mac       = tx_dst;

endmodule
`default_nettype wire

// File: tb/tb_micro_udp_engine_arp_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_micro_udp_engine_arp_tx
//  Description : Self-checking bench for micro_udp_engine_arp_tx (default
//                build, gratuitous ARP not compiled in). Expected beats are
//                queued when stimulus is driven and compared as beats leave.
//  Revision    : 1.0 - initial version
// ============================================================================
module tb_micro_udp_engine_arp_tx;

  localparam logic [47:0] MAC   = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [31:0] IP    = 32'hC0A8_0101;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset;
  logic         arp_reply;
  logic [47:0]  arp_reply_tha;
  logic [31:0]  arp_reply_tpa;
  logic         arp_request_valid;
  logic [31:0]  arp_request_tpa;
  logic         arp_request_ready;
  logic [255:0] arp_tx_data;
  logic [4:0]   arp_tx_empty;
  logic         arp_tx_startofpacket;
  logic         arp_tx_endofpacket;
  logic         arp_tx_valid;
  logic         arp_tx_ready;
  logic [47:0]  arp_tx_dst_mac;
  logic [15:0]  reply_drop_cnt;

  micro_udp_engine_arp_tx #(
    .CONFIG_MAC_ADDR  (MAC),
    .CONFIG_IP_ADDR   (IP),
    .REPLY_FIFO_DEPTH (4),
    .GRAT_PERIOD      (100)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .arp_reply            (arp_reply),
    .arp_reply_tha        (arp_reply_tha),
    .arp_reply_tpa        (arp_reply_tpa),
    .arp_request_valid    (arp_request_valid),
    .arp_request_tpa      (arp_request_tpa),
    .arp_request_ready    (arp_request_ready),
    .arp_tx_data          (arp_tx_data),
    .arp_tx_empty         (arp_tx_empty),
    .arp_tx_startofpacket (arp_tx_startofpacket),
    .arp_tx_endofpacket   (arp_tx_endofpacket),
    .arp_tx_valid         (arp_tx_valid),
    .arp_tx_ready         (arp_tx_ready),
    .arp_tx_dst_mac       (arp_tx_dst_mac),
    .reply_drop_cnt       (reply_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [47:0]  dst;
  } beat_t;

  typedef struct {
    logic        is_reply;
    logic [47:0] tha;
    logic [31:0] tpa;
  } vec_t;

  beat_t sb[$];
  beat_t mon_exp;
  vec_t  vecs[5];
  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t model(input logic is_reply, input logic [47:0] tha, input logic [31:0] tpa);
    beat_t b;
    b.data = {16'h0001, 16'h0800, 8'h06, 8'h04,
              (is_reply ? 16'h0002 : 16'h0001),
              MAC, IP, (is_reply ? tha : 48'h0), tpa, 32'h0};
    b.dst  = is_reply ? tha : BCAST;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected beats still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Beat monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && arp_tx_valid && arp_tx_ready) begin
      beats++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h, expected no beat", arp_tx_data);
      end else begin
        mon_exp = sb.pop_front();
        check("beat_data", arp_tx_data, mon_exp.data);
        check("beat_dst_mac", {208'h0, arp_tx_dst_mac}, {208'h0, mon_exp.dst});
        check("beat_empty", {251'h0, arp_tx_empty}, 256'd4);
        check("beat_sop_eop", {254'h0, arp_tx_startofpacket, arp_tx_endofpacket}, 256'd3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [255:0] held;
    logic         stable;
    int           start;

    vecs[0] = '{1'b1, 48'h00_11_22_33_44_55, 32'hC0A8_010A};
    vecs[1] = '{1'b0, 48'h0,                 32'hC0A8_0105};
    vecs[2] = '{1'b1, 48'hFF_FF_FF_FF_FF_FE, 32'hFFFF_FFFF};
    vecs[3] = '{1'b1, 48'h00_00_00_00_00_01, 32'h0000_0000};
    vecs[4] = '{1'b0, 48'h0,                 32'hFFFF_FFFF};

    reset = 1'b1;
    arp_reply = 1'b0;
    arp_reply_tha = '0;
    arp_reply_tpa = '0;
    arp_request_valid = 1'b0;
    arp_request_tpa = '0;
    arp_tx_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_valid", {255'h0, arp_tx_valid}, 256'd0);
    check("rst_sop_eop", {254'h0, arp_tx_startofpacket, arp_tx_endofpacket}, 256'd0);
    check("rst_data", arp_tx_data, 256'd0);
    check("rst_empty", {251'h0, arp_tx_empty}, 256'd0);
    check("rst_dst_mac", {208'h0, arp_tx_dst_mac}, 256'd0);
    check("rst_drop_cnt", {240'h0, reply_drop_cnt}, 256'd0);
    check("rst_req_ready", {255'h0, arp_request_ready}, 256'd1);
    tick();
    reset = 1'b0;
    arp_tx_ready = 1'b1;

    // Single reply latency: pulse sampled at edge N, valid after edge N+1
    sb.push_back(model(1'b1, 48'h00_11_22_33_44_55, 32'hC0A8_010A));
    arp_reply = 1'b1; arp_reply_tha = 48'h00_11_22_33_44_55; arp_reply_tpa = 32'hC0A8_010A;
    tick();
    arp_reply = 1'b0;
    @(negedge clk);
    check("reply_lat_n", {255'h0, arp_tx_valid}, 256'd0);
    tick();
    @(negedge clk);
    check("reply_lat_n1", {255'h0, arp_tx_valid}, 256'd1);
    wait_drain("reply_lat_drain", 10);

    // Table-driven vectors with ready held high
    for (int i = 0; i < 5; i++) begin
      sb.push_back(model(vecs[i].is_reply, vecs[i].tha, vecs[i].tpa));
      if (vecs[i].is_reply) begin
        arp_reply = 1'b1; arp_reply_tha = vecs[i].tha; arp_reply_tpa = vecs[i].tpa;
        tick();
        arp_reply = 1'b0;
      end else begin
        arp_request_valid = 1'b1; arp_request_tpa = vecs[i].tpa;
        tick();
        arp_request_valid = 1'b0;
      end
      wait_drain("vec_drain", 20);
    end

    // Request held under backpressure
    arp_tx_ready = 1'b0;
    arp_request_valid = 1'b1; arp_request_tpa = 32'hC0A8_0105;
    tick();
    arp_request_valid = 1'b0;
    @(negedge clk);
    check("req_ready_after_accept", {255'h0, arp_request_ready}, 256'd0);
    check("req_valid_not_yet", {255'h0, arp_tx_valid}, 256'd0);
    tick();
    @(negedge clk);
    check("req_valid_n1", {255'h0, arp_tx_valid}, 256'd1);
    check("req_ready_restored", {255'h0, arp_request_ready}, 256'd1);
    held = arp_tx_data;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (!arp_tx_valid || arp_tx_data !== held) stable = 1'b0;
    end
    check("send_hold_stable", {255'h0, stable}, 256'd1);
    sb.push_back(model(1'b0, 48'h0, 32'hC0A8_0105));
    tick();
    arp_tx_ready = 1'b1;
    wait_drain("req_bp_drain", 10);

    // Reply and request in the same cycle: reply goes first
    sb.push_back(model(1'b1, 48'h66_77_88_99_AA_BB, 32'h0A01_0203));
    sb.push_back(model(1'b0, 48'h0, 32'h0A01_0204));
    arp_reply = 1'b1; arp_reply_tha = 48'h66_77_88_99_AA_BB; arp_reply_tpa = 32'h0A01_0203;
    arp_request_valid = 1'b1; arp_request_tpa = 32'h0A01_0204;
    tick();
    arp_reply = 1'b0;
    arp_request_valid = 1'b0;
    wait_drain("prio_drain", 20);

    // Six back-to-back replies with depth 4 under backpressure: one dropped
    arp_tx_ready = 1'b0;
    start = beats;
    for (int i = 0; i < 6; i++) begin
      arp_reply = 1'b1;
      arp_reply_tha = 48'h0A_00_00_00_00_00 + 48'(i);
      arp_reply_tpa = 32'h0A00_0000 + 32'(i);
      if (i < 5) sb.push_back(model(1'b1, arp_reply_tha, arp_reply_tpa));
      tick();
    end
    arp_reply = 1'b0;
    tick();
    @(negedge clk);
    check("overflow_drop_cnt", {240'h0, reply_drop_cnt}, 256'd1);
    check("overflow_valid_held", {255'h0, arp_tx_valid}, 256'd1);
    tick();
    arp_tx_ready = 1'b1;
    wait_drain("overflow_drain", 40);
    repeat (20) tick();
    check("overflow_beat_count", 256'(beats - start), 256'd5);

    // Reset during SEND abandons everything
    arp_tx_ready = 1'b0;
    arp_reply = 1'b1; arp_reply_tha = 48'h12_34_56_78_9A_BC; arp_reply_tpa = 32'h0102_0304;
    tick();
    arp_reply_tha = 48'h12_34_56_78_9A_BD; arp_reply_tpa = 32'h0102_0305;
    arp_request_valid = 1'b1; arp_request_tpa = 32'h0102_0306;
    tick();
    arp_reply = 1'b0;
    arp_request_valid = 1'b0;
    @(negedge clk);
    check("prereset_valid", {255'h0, arp_tx_valid}, 256'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_send_valid", {255'h0, arp_tx_valid}, 256'd0);
    check("reset_send_drop_cnt", {240'h0, reply_drop_cnt}, 256'd0);
    check("reset_send_req_ready", {255'h0, arp_request_ready}, 256'd1);
    tick();
    arp_tx_ready = 1'b1;
    start = beats;
    // Long idle window also covers the absence of gratuitous beats
    repeat (300) tick();
    check("post_reset_no_beats", 256'(beats - start), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
